c64_key_injector: RTL and testbench

Keyboard-side responder for the C64 keyboard matrix. The C64 core drives keyboard_ROW (active-low row select) and reads keyboard_COL (active-low column sense). This block replaces the constant all-ones column tie-off in benches and on boards. It accepts a stream of key codes over a valid/ready handshake and presses each key for a programmable time, with optional left-shift. It then releases the key for a programmable gap, so scripted typing (e.g. LOAD "$",8) runs unattended.

---
 rtl/c64_kbd_pkg.sv | 43 ++++
 rtl/c64_key_injector_if.sv | 17 +
 rtl/c64_matrix_sense.sv | 32 +++
 rtl/c64_key_injector.sv | 130 +++++++++++++
 tb/tb_c64_key_injector.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/c64_kbd_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : c64_kbd_pkg
//  Purpose  : Shared types and constants for the C64 keyboard key injector:
//             FSM state encoding, key_code field positions, the left-shift
//             matrix position and common key codes for scripted typing.
//  Revision : 1.0  initial release
// ============================================================================
package c64_kbd_pkg;

    // Injector sequencing states, explicit 2-bit encoding
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_HOLD  = 2'd2,
        ST_GAP   = 2'd3
    } kbd_state_t;

    // key_code layout: {shift, row[2:0], col[2:0]}
    localparam int SHIFT_BIT = 6;
    localparam int ROW_MSB   = 5;
    localparam int ROW_LSB   = 3;
    localparam int COL_MSB   = 2;
    localparam int COL_LSB   = 0;

    // Left shift sits at row 1, column 7 of the C64 matrix
    localparam logic [2:0] SHIFT_ROW = 3'd1;
    localparam logic [2:0] SHIFT_COL = 3'd7;

    // Unshifted key codes for scripted typing
    localparam logic [6:0] KEY_L      = 7'h2A;  // row 5, col 2
    localparam logic [6:0] KEY_O      = 7'h26;  // row 4, col 6
    localparam logic [6:0] KEY_A      = 7'h0A;  // row 1, col 2
    localparam logic [6:0] KEY_D      = 7'h12;  // row 2, col 2
    localparam logic [6:0] KEY_SPACE  = 7'h3C;  // row 7, col 4
    localparam logic [6:0] KEY_RETURN = 7'h01;  // row 0, col 1
    localparam logic [6:0] KEY_2      = 7'h3B;  // row 7, col 3
    localparam logic [6:0] KEY_4      = 7'h0B;  // row 1, col 3
    localparam logic [6:0] KEY_COMMA  = 7'h2F;  // row 5, col 7
    localparam logic [6:0] KEY_8      = 7'h1B;  // row 3, col 3

endpackage
`default_nettype wire

// File: rtl/c64_key_injector_if.sv
`default_nettype none
// ============================================================================
//  Module   : c64_key_injector_if
//  Purpose  : Valid/ready key-code stream into the key injector.
//  Revision : 1.0  initial release
// ============================================================================
interface c64_key_injector_if;
    logic       key_valid;
    logic       key_ready;
    logic [6:0] key_code;

    // Code source (script player, testbench)
    modport master (output key_valid, output key_code, input key_ready);
    // Key injector
    modport slave  (input key_valid, input key_code, output key_ready);
endinterface
`default_nettype wire

// File: rtl/c64_matrix_sense.sv
`default_nettype none
// ============================================================================
//  Module   : c64_matrix_sense
//  Purpose  : Combinational keyboard-matrix responder for up to two pressed
//             positions. A column is pulled low when a pressed key in that
//             column sits on a currently selected (low) row.
//  Revision : 1.0  initial release
// ============================================================================
module c64_matrix_sense (
    input  wire logic [7:0] i_row_sel,   // active-low row select
    input  wire logic       i_en_a,
    input  wire logic [2:0] i_row_a,
    input  wire logic [2:0] i_col_a,
    input  wire logic       i_en_b,
    input  wire logic [2:0] i_row_b,
    input  wire logic [2:0] i_col_b,
    output logic      [7:0] o_col        // active-low column sense
);

    // Wired-AND of both pressed positions onto the column lines
    always_comb begin
        o_col = 8'hFF;
        for (int c = 0; c < 8; c++) begin
            if (i_en_a && (i_col_a == 3'(c)) && !i_row_sel[i_row_a])
                o_col[c] = 1'b0;
            if (i_en_b && (i_col_b == 3'(c)) && !i_row_sel[i_row_b])
                o_col[c] = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/c64_key_injector.sv
`default_nettype none
// ============================================================================
//  Module   : c64_key_injector
//  Purpose  : Presses one C64 key per accepted code for HOLD_CYCLES (with an
//             optional SETUP_CYCLES lead-in of left shift), then releases all
//             keys for GAP_CYCLES before accepting the next code.
//  Revision : 1.0  initial release
// ============================================================================
module c64_key_injector
    import c64_kbd_pkg::*;
#(
    parameter int HOLD_CYCLES  = 400000,
    parameter int GAP_CYCLES   = 400000,
    parameter int SETUP_CYCLES = 80000,
    parameter int CNT_W        = 20
) (
    input  wire logic           clk,
    input  wire logic           reset,         // asynchronous, active-low
    c64_key_injector_if.slave   kbd,
    input  wire logic     [7:0] keyboard_ROW,
    output logic          [7:0] keyboard_COL,
    output logic                busy
);

    // Counter reload values: a state lasts exactly LOAD+1 clocks
    localparam logic [CNT_W-1:0] C_SETUP_LOAD = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_HOLD_LOAD  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_GAP_LOAD   = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_ONE        = CNT_W'(1);

    kbd_state_t       r_state,    w_state_nxt;
    logic [CNT_W-1:0] r_cnt,      w_cnt_nxt;
    logic [5:0]       r_key,      w_key_nxt;      // {row, col}; shift tracked by r_shift_on
    logic             r_key_on,   w_key_on_nxt;
    logic             r_shift_on, w_shift_on_nxt;
    logic             w_accept;

    assign w_accept = kbd.key_valid && (r_state == ST_IDLE);

    // State, counter and press flags; reset releases every key immediately
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_key      <= '0;
            r_key_on   <= 1'b0;
            r_shift_on <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_key      <= w_key_nxt;
            r_key_on   <= w_key_on_nxt;
            r_shift_on <= w_shift_on_nxt;
        end
    end

    // Sequencing: IDLE -> [SETUP] -> HOLD -> GAP -> IDLE
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_key_nxt      = r_key;
        w_key_on_nxt   = r_key_on;
        w_shift_on_nxt = r_shift_on;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_key_nxt = kbd.key_code[ROW_MSB:COL_LSB];
                    if (kbd.key_code[SHIFT_BIT]) begin
                        w_state_nxt    = ST_SETUP;
                        w_shift_on_nxt = 1'b1;
                        w_cnt_nxt      = C_SETUP_LOAD;
                    end else begin
                        w_state_nxt  = ST_HOLD;
                        w_key_on_nxt = 1'b1;
                        w_cnt_nxt    = C_HOLD_LOAD;
                    end
                end
            end
            ST_SETUP: begin
                if (r_cnt == '0) begin
                    w_state_nxt  = ST_HOLD;
                    w_key_on_nxt = 1'b1;
                    w_cnt_nxt    = C_HOLD_LOAD;
                end else begin
                    w_cnt_nxt = r_cnt - C_ONE;
                end
            end
            ST_HOLD: begin
                if (r_cnt == '0) begin
                    w_state_nxt    = ST_GAP;
                    w_key_on_nxt   = 1'b0;
                    w_shift_on_nxt = 1'b0;
                    w_cnt_nxt      = C_GAP_LOAD;
                end else begin
                    w_cnt_nxt = r_cnt - C_ONE;
                end
            end
            ST_GAP: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - C_ONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Status outputs decoded from the registered state only
    always_comb begin
        kbd.key_ready = (r_state == ST_IDLE);
        busy          = (r_state != ST_IDLE);
    end

    // Column response: pressed key plus left shift, combinational on ROW
    c64_matrix_sense u_sense (
        .i_row_sel (keyboard_ROW),
        .i_en_a    (r_key_on),
        .i_row_a   (r_key[ROW_MSB:ROW_LSB]),
        .i_col_a   (r_key[COL_MSB:COL_LSB]),
        .i_en_b    (r_shift_on),
        .i_row_b   (SHIFT_ROW),
        .i_col_b   (SHIFT_COL),
        .o_col     (keyboard_COL)
    );

endmodule
`default_nettype wire

// File: tb/tb_c64_key_injector.sv
`default_nettype none
// ============================================================================
//  Module   : tb_c64_key_injector
//  Purpose  : Self-checking bench for c64_key_injector (HOLD=4, GAP=3,
//             SETUP=2). Stimulus queues per-cycle expectations; a monitor on
//             the falling edge pops and compares them.
//  Revision : 1.0  initial release
// ============================================================================
module tb_c64_key_injector;
    import c64_kbd_pkg::*;

    logic       clk;
    logic       reset;
    logic [7:0] row;
    logic [7:0] col;
    logic       busy;

    c64_key_injector_if kif ();

    c64_key_injector #(
        .HOLD_CYCLES  (4),
        .GAP_CYCLES   (3),
        .SETUP_CYCLES (2),
        .CNT_W        (20)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .kbd          (kif),
        .keyboard_ROW (row),
        .keyboard_COL (col),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] col;
        logic       rdy;
        logic       bsy;
        int         tag;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    // Monitor: one expectation per clock, compared mid-cycle
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (q.size() > 0) begin
            e = q.pop_front();
            n_checks++;
            if (col !== e.col || kif.key_ready !== e.rdy || busy !== e.bsy) begin
                n_fail++;
                $display("FAIL t%0d cyc%0d: col=%h rdy=%b busy=%b, required col=%h rdy=%b busy=%b",
                         e.tag, cyc, col, kif.key_ready, busy, e.col, e.rdy, e.bsy);
            end
        end
    end

    task automatic check_now(input logic [7:0] c, input logic r, input logic b, input int tag);
        n_checks++;
        if (col !== c || kif.key_ready !== r || busy !== b) begin
            n_fail++;
            $display("FAIL t%0d reset-check: col=%h rdy=%b busy=%b, required col=%h rdy=%b busy=%b",
                     tag, col, kif.key_ready, busy, c, r, b);
        end
    endtask

    // Queue this cycle's expectation, then advance to just after the next edge
    task automatic step(input logic [7:0] c, input logic r, input logic b, input int tag);
        exp_t e;
        e.col = c; e.rdy = r; e.bsy = b; e.tag = tag;
        q.push_back(e);
        @(posedge clk); #1;
    endtask

    task automatic dwell(input int n, input logic [7:0] c, input logic r, input logic b, input int tag);
        for (int i = 0; i < n; i++) step(c, r, b, tag);
    endtask

    // Busy step with a scrambled code on the bus (must not be latched)
    task automatic step_g(input logic [7:0] c, input int tag);
        kif.key_code = 7'($urandom);
        step(c, 1'b0, 1'b1, tag);
    endtask

    function automatic logic [7:0] model_col(input logic [7:0] rs, input logic [6:0] kc,
                                             input bit k_on, input bit s_on);
        logic [7:0] r;
        r = 8'hFF;
        if (k_on && !rs[kc[5:3]]) r[kc[2:0]] = 1'b0;
        if (s_on && !rs[1]) r[7] = 1'b0;
        return r;
    endfunction

    logic [6:0] script [10];

    initial begin
        script = '{KEY_L, KEY_O, KEY_A, KEY_D, KEY_SPACE,
                   7'h40 | KEY_2, 7'h40 | KEY_4, 7'h40 | KEY_2, KEY_COMMA, KEY_8};
        reset = 1'b0; row = 8'hFF; kif.key_valid = 1'b0; kif.key_code = 7'h00;
        repeat (2) @(posedge clk);
        #1;
        check_now(8'hFF, 1'b1, 1'b0, 0);
        reset = 1'b1;

        // T1: reset asserted mid-HOLD with all rows selected
        row = 8'h00; kif.key_valid = 1'b1; kif.key_code = 7'h0A;
        step(8'hFF, 1'b1, 1'b0, 1);
        kif.key_valid = 1'b0;
        dwell(2, 8'hFB, 1'b0, 1'b1, 1);
        #2 reset = 1'b0;
        #1 check_now(8'hFF, 1'b1, 1'b0, 1);
        @(posedge clk); #1;
        check_now(8'hFF, 1'b1, 1'b0, 1);
        reset = 1'b1;
        dwell(3, 8'hFF, 1'b1, 1'b0, 1);

        // T2: plain key row1/col2
        row = 8'hFD; kif.key_valid = 1'b1; kif.key_code = 7'h0A;
        step(8'hFF, 1'b1, 1'b0, 2);
        kif.key_valid = 1'b0; kif.key_code = 7'h7F;
        dwell(4, 8'hFB, 1'b0, 1'b1, 2);
        dwell(3, 8'hFF, 1'b0, 1'b1, 2);
        step(8'hFF, 1'b1, 1'b0, 2);

        // T3: row selectivity while the key is held
        kif.key_valid = 1'b1; kif.key_code = 7'h0A;
        step(8'hFF, 1'b1, 1'b0, 3);
        kif.key_valid = 1'b0;
        row = 8'hFE; step(8'hFF, 1'b0, 1'b1, 3);
        row = 8'hFD; step(8'hFB, 1'b0, 1'b1, 3);
        row = 8'hFB; step(8'hFF, 1'b0, 1'b1, 3);
        row = 8'h00; step(8'hFB, 1'b0, 1'b1, 3);
        row = 8'hFF; dwell(3, 8'hFF, 1'b0, 1'b1, 3);
        kif.key_valid = 1'b1;
        step(8'hFF, 1'b1, 1'b0, 3);
        kif.key_valid = 1'b0;
        dwell(4, 8'hFF, 1'b0, 1'b1, 3);
        dwell(3, 8'hFF, 1'b0, 1'b1, 3);
        step(8'hFF, 1'b1, 1'b0, 3);

        // T4: shifted key row1/col4
        row = 8'hFD; kif.key_valid = 1'b1; kif.key_code = 7'h4C;
        step(8'hFF, 1'b1, 1'b0, 4);
        kif.key_valid = 1'b0;
        dwell(2, 8'h7F, 1'b0, 1'b1, 4);
        dwell(4, 8'h6F, 1'b0, 1'b1, 4);
        dwell(3, 8'hFF, 1'b0, 1'b1, 4);
        step(8'hFF, 1'b1, 1'b0, 4);

        // T6: any-key scan on a shifted row0 key, then shifted key in column 7
        row = 8'h00; kif.key_valid = 1'b1; kif.key_code = 7'h41;
        step(8'hFF, 1'b1, 1'b0, 6);
        kif.key_valid = 1'b0;
        dwell(2, 8'h7F, 1'b0, 1'b1, 6);
        dwell(4, 8'h7D, 1'b0, 1'b1, 6);
        dwell(3, 8'hFF, 1'b0, 1'b1, 6);
        row = 8'hDF; kif.key_valid = 1'b1; kif.key_code = 7'h6F;
        step(8'hFF, 1'b1, 1'b0, 6);
        kif.key_valid = 1'b0;
        dwell(2, 8'hFF, 1'b0, 1'b1, 6);
        dwell(4, 8'h7F, 1'b0, 1'b1, 6);
        dwell(3, 8'hFF, 1'b0, 1'b1, 6);
        step(8'hFF, 1'b1, 1'b0, 6);

        // T5: LOAD "$",8 with key_valid held high and the bus churning
        row = 8'h00; kif.key_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            kif.key_code = script[i];
            step(8'hFF, 1'b1, 1'b0, 5);
            if (script[i][6])
                for (int k = 0; k < 2; k++) step_g(model_col(row, script[i], 1'b0, 1'b1), 5);
            for (int k = 0; k < 4; k++) step_g(model_col(row, script[i], 1'b1, script[i][6]), 5);
            for (int k = 0; k < 3; k++) step_g(8'hFF, 5);
        end
        kif.key_valid = 1'b0;
        step(8'hFF, 1'b1, 1'b0, 5);

        // Drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
